// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes/InvSubBytes over a 128-bit state, LANES bytes per cycle.
// aes_sbox_lut is one S-box lane computed as GF(2^8) inverse plus affine map.
module aes_sbox_lut (
  input  logic       op_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = product of x^2 .. x^128; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  always_comb begin
    data_o = 8'h00;
    if (op_i) data_o = gf_inv(inv_affine(data_i));
    else      data_o = fwd_affine(gf_inv(data_i));
  end

endmodule

module aes_sub_bytes_seq #(
  parameter int LANES = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         op_i,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // state | meaning
  // IDLE  | ready for a new state; RUN | substituting LANES bytes per cycle; DONE | result held for consumer
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [127:0]    st_q, st_d;
  logic            op_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q, out_valid_q, busy_q;
  logic [3:0]      base;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  always_comb base = 4'(int'(cnt_q) * LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [3:0] idx;
    assign idx        = base + 4'(j);
    assign lane_in[j] = st_q[{idx, 3'b000} +: 8];
    aes_sbox_lut u_sbox (
      .op_i   (op_q),
      .data_i (lane_in[j]),
      .data_o (lane_out[j])
    );
  end

  always_comb begin
    st_d = st_q;
    for (int j = 0; j < LANES; j++) begin
      st_d[{base + 4'(j), 3'b000} +: 8] = lane_out[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= IDLE;
      st_q        <= '0;
      op_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            st_q       <= data_i;
            op_q       <= op_i;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          st_q  <= st_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  // Only the finished state is ever visible on the output bus
  assign data_o      = out_valid_q ? st_q : '0;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: three instances (LANES 1, 4, 16) checked against a
// table model built from brute-force GF(2^8) inverses and the bitwise FIPS-197 affine map.
module tb_aes_sub_bytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   clr, in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [127:0] din  [3];
  logic [127:0] dout [3];

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb_f [256];
  logic [7:0]   sb_i [256];

  aes_sub_bytes_seq #(.LANES(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[0]), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .op_i(op[0]), .data_i(din[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .data_o(dout[0]), .busy_o(busy[0]));

  aes_sub_bytes_seq #(.LANES(4)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[1]), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .op_i(op[1]), .data_i(din[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .data_o(dout[1]), .busy_o(busy[1]));

  aes_sub_bytes_seq #(.LANES(16)) u_l16 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[2]), .in_valid_i(in_valid[2]),
    .in_ready_o(in_ready[2]), .op_i(op[2]), .data_i(din[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .data_o(dout[2]), .busy_o(busy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_f[x] = s;
      sb_i[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic o, input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = o ? sb_i[d[8*i +: 8]] : sb_f[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [2:0] flags(input int k);
    return {in_ready[k], out_valid[k], busy[k]};
  endfunction

  task automatic run_op(input int k, input logic o, input logic [127:0] d, input logic [127:0] e,
                        input int hold, input bit wiggle, input string tag);
    int lat_exp = (k == 0) ? 17 : (k == 1) ? 5 : 2;
    int cyc;
    bit busy_ok = 1'b1;
    bit stable_ok = 1'b1;
    logic [127:0] first;
    exp_q.push_back(e);
    @(negedge clk);
    chk({tag, "_rdy"}, 128'(in_ready[k]), 128'd1);
    in_valid[k] = 1'b1; op[k] = o; din[k] = d;
    @(negedge clk);
    in_valid[k] = 1'b0;
    cyc = 1;
    while (!out_valid[k] && cyc < 40) begin
      if (!busy[k] || in_ready[k] || dout[k] !== '0) busy_ok = 1'b0;
      if (wiggle) begin
        op[k]  = ~op[k];
        din[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 128'(cyc), 128'(lat_exp));
    chk({tag, "_busy"}, 128'(busy_ok), 128'd1);
    first = dout[k];
    repeat (hold) begin
      if (dout[k] !== first || in_ready[k] || !out_valid[k] || !busy[k]) stable_ok = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) chk({tag, "_hold"}, 128'(stable_ok), 128'd1);
    out_ready[k] = 1'b1;
    chk({tag, "_data"}, dout[k], exp_q.pop_front());
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk({tag, "_post_flags"}, 128'(flags(k)), 128'(3'b100));
    chk({tag, "_post_data"}, dout[k], '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d;
    bit quiet;
    int n;
    build_tables();
    rst_n = 1'b0; clr = '0; in_valid = '0; op = '0; out_ready = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_flags", 128'(flags(k)), 128'(3'b100));
      chk("rst_data", dout[k], '0);
    end
    rst_n = 1'b1;

    run_op(0, 1'b0, {16{8'h00}}, {16{8'h63}}, 0, 1'b0, "l1_zero");
    run_op(0, 1'b1, {16{8'h63}}, {16{8'h00}}, 0, 1'b0, "l1_inv63");
    run_op(0, 1'b0, {{15{8'h00}}, 8'h53}, {{15{8'h63}}, 8'hED}, 0, 1'b0, "l1_53");

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(1, 1'b1, d, model(1'b1, d), 0, 1'b1, "l4_wig_inv");
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(1, 1'b0, d, model(1'b0, d), 0, 1'b1, "l4_wig_fwd");

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(2, 1'b0, d, model(1'b0, d), 10, 1'b0, "l16_hold");

    repeat (3) @(negedge clk);
    chk("l16_idle_noval", 128'(flags(2)), 128'(3'b100));

    clr[2] = 1'b1; in_valid[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0; in_valid[2] = 1'b0;
    chk("l16_clr_vs_in", 128'(flags(2)), 128'(3'b100));

    in_valid[1] = 1'b1; op[1] = 1'b0; din[1] = {16{8'h11}};
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk("l4_clr_run_flags", 128'(flags(1)), 128'(3'b100));
    chk("l4_clr_run_data", dout[1], '0);
    quiet = 1'b1;
    repeat (6) begin
      if (out_valid[1]) quiet = 1'b0;
      @(negedge clk);
    end
    chk("l4_clr_no_beat", 128'(quiet), 128'd1);

    in_valid[2] = 1'b1; op[2] = 1'b1; din[2] = {16{8'h22}};
    @(negedge clk);
    in_valid[2] = 1'b0;
    n = 0;
    while (!out_valid[2] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("l16_clr_reach_done", 128'(out_valid[2]), 128'd1);
    clr[2] = 1'b1; out_ready[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0; out_ready[2] = 1'b0;
    chk("l16_clr_done_flags", 128'(flags(2)), 128'(3'b100));
    chk("l16_clr_done_data", dout[2], '0);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(2, 1'b1, d, model(1'b1, d), 0, 1'b0, "l16_after_clr");

    in_valid[0] = 1'b1; op[0] = 1'b0; din[0] = {16{8'h33}};
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("midrst_flags", 128'(flags(k)), 128'(3'b100));
      chk("midrst_data", dout[k], '0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_beat", 128'(flags(0)), 128'(3'b100));

    for (int o = 0; o < 2; o++) begin
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(b*16 + i);
        run_op(b % 3, o[0], d, model(o[0], d), 0, 1'b0, o ? "sweep_inv" : "sweep_fwd");
      end
    end

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
